// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and state definitions for the multi-cycle CPU.
// Imported by the controller and its helpers.
package cpu_pkg;

   localparam logic [1:0] REGISTER_TYPE_OPCODE  = 2'b00;
   localparam logic [1:0] IMMEDIATE_TYPE_OPCODE = 2'b01;
   localparam logic [1:0] MEMORY_TYPE_OPCODE    = 2'b10;
   localparam logic [1:0] BRANCH_TYPE_OPCODE    = 2'b11;

   localparam logic [3:0] FN_LOAD  = 4'b0000;
   localparam logic [3:0] FN_STORE = 4'b0001;
   localparam logic [3:0] FN_JMP   = 4'b0000;
   localparam logic [3:0] FN_BZ    = 4'b0001;
   localparam logic [3:0] FN_BNZ   = 4'b0010;
   localparam logic [3:0] FN_HALT  = 4'b1111;

   localparam logic [2:0] ALU_ADD = 3'b000;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_HALT     = 4'd10
   } ctrl_state_e;

   function automatic logic op_legal(input logic [5:0] op);
      logic [3:0] fn;
      logic       ok;
      fn = op[3:0];
      ok = 1'b0;
      case (op[5:4])
         REGISTER_TYPE_OPCODE,
         IMMEDIATE_TYPE_OPCODE: ok = ~fn[3];
         MEMORY_TYPE_OPCODE:    ok = (fn == FN_LOAD) || (fn == FN_STORE);
         default:               ok = (fn == FN_JMP) || (fn == FN_BZ) ||
                                     (fn == FN_BNZ) || (fn == FN_HALT);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles; flags a timeout on the
// last allowed cycle when no acknowledge arrives.
module mem_wait_timer #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned CNT_W      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || ready) begin
         cnt_d = '0;
      end else if (active) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Acknowledge on the final allowed cycle still counts as success.
   assign timeout = active && !ready && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: fetch/decode/execute/memory/write-back control
// with a shared memory port and bounded handshake wait.
module multicycle_controller
   import cpu_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] instruction,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       addr_sel,
   output logic       ir_write,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       reg_write,
   output logic       wb_sel,
   output logic [2:0] alu_op,
   output logic       sel_alu_src_reg,
   output logic       sel_alu_src_const,
   output logic       halted,
   output logic       illegal_op,
   output logic       mem_fault
);

   ctrl_state_e state_q;
   ctrl_state_e state_d;
   logic        mem_fault_q;
   logic        mem_fault_d;
   logic        mem_active;
   logic        timeout;
   logic [1:0]  op_type;
   logic [3:0]  op_fn;
   logic        legal;

   assign op_type = instruction[5:4];
   assign op_fn   = instruction[3:0];
   assign legal   = op_legal(instruction);

   assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                       (state_q == S_MEM_WR);

   mem_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!mem_active),
      .active  (mem_active),
      .ready   (mem_ready),
      .timeout (timeout)
   );

   always_comb begin
      state_d     = state_q;
      mem_fault_d = mem_fault_q;
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH, S_MEM_RD, S_MEM_WR: begin
            if (mem_ready) begin
               unique case (state_q)
                  S_FETCH:  state_d = S_DECODE;
                  S_MEM_RD: state_d = S_MEM_WB;
                  default:  state_d = S_FETCH;
               endcase
            end else if (timeout) begin
               state_d     = S_HALT;
               mem_fault_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (!legal) begin
               state_d = S_FETCH;
            end else begin
               unique case (op_type)
                  REGISTER_TYPE_OPCODE:  state_d = S_EXEC_R;
                  IMMEDIATE_TYPE_OPCODE: state_d = S_EXEC_I;
                  MEMORY_TYPE_OPCODE:    state_d = S_MEM_ADDR;
                  default: state_d = (op_fn == FN_HALT) ? S_HALT : S_BRANCH;
               endcase
            end
         end
         S_MEM_ADDR: state_d = (op_fn == FN_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_EXEC_R, S_EXEC_I, S_MEM_WB, S_BRANCH: state_d = S_FETCH;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   always_comb begin
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      addr_sel          = 1'b0;
      ir_write          = 1'b0;
      pc_inc            = 1'b0;
      pc_load           = 1'b0;
      reg_write         = 1'b0;
      wb_sel            = 1'b0;
      alu_op            = 3'b000;
      sel_alu_src_reg   = 1'b0;
      sel_alu_src_const = 1'b0;
      halted            = 1'b0;
      illegal_op        = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            pc_inc   = mem_ready;
         end
         S_DECODE: illegal_op = !legal;
         S_EXEC_R: begin
            alu_op          = instruction[2:0];
            sel_alu_src_reg = 1'b1;
            reg_write       = 1'b1;
         end
         S_EXEC_I: begin
            alu_op            = instruction[2:0];
            sel_alu_src_const = 1'b1;
            reg_write         = 1'b1;
         end
         S_MEM_ADDR: begin
            alu_op            = ALU_ADD;
            sel_alu_src_const = 1'b1;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            addr_sel = 1'b1;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
            wb_sel    = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            addr_sel  = 1'b1;
         end
         S_BRANCH: begin
            pc_load = (op_fn == FN_JMP) ||
                      ((op_fn == FN_BZ) && zero) ||
                      ((op_fn == FN_BNZ) && !zero);
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: expected output vectors queued per driven cycle,
// popped and compared on the falling edge.
module tb_multicycle_controller;

   logic       clk;
   logic       rst;
   logic [5:0] instruction;
   logic       zero;
   logic       mem_ready;
   logic       mem_read;
   logic       mem_write;
   logic       addr_sel;
   logic       ir_write;
   logic       pc_inc;
   logic       pc_load;
   logic       reg_write;
   logic       wb_sel;
   logic [2:0] alu_op;
   logic       sel_alu_src_reg;
   logic       sel_alu_src_const;
   logic       halted;
   logic       illegal_op;
   logic       mem_fault;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_item_t;

   sb_item_t sb[$];
   int checks   = 0;
   int failures = 0;

   multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .instruction       (instruction),
      .zero              (zero),
      .mem_ready         (mem_ready),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .addr_sel          (addr_sel),
      .ir_write          (ir_write),
      .pc_inc            (pc_inc),
      .pc_load           (pc_load),
      .reg_write         (reg_write),
      .wb_sel            (wb_sel),
      .alu_op            (alu_op),
      .sel_alu_src_reg   (sel_alu_src_reg),
      .sel_alu_src_const (sel_alu_src_const),
      .halted            (halted),
      .illegal_op        (illegal_op),
      .mem_fault         (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {mr,mw,as,ir,pi,pl,rw,wb,alu[2:0],src_reg,src_const,halt,ill,fault}
   function automatic logic [15:0] mk(
      input logic mr, mw, as_, ir, pi, pl, rw, wb,
      input logic [2:0] alu,
      input logic sr, sc, h, il, mf);
      return {mr, mw, as_, ir, pi, pl, rw, wb, alu, sr, sc, h, il, mf};
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_item_t it;
         it = sb.pop_front();
         check(it.tag,
               {16'd0, mem_read, mem_write, addr_sel, ir_write, pc_inc,
                pc_load, reg_write, wb_sel, alu_op, sel_alu_src_reg,
                sel_alu_src_const, halted, illegal_op, mem_fault},
               {16'd0, it.exp});
      end
   end

   logic [15:0] e_z, e_fw, e_fa, e_ill, e_ma, e_mr, e_mwb, e_mw;
   logic [15:0] e_br, e_hlt, e_hlf;

   task automatic cyc(input string tag, input logic rdy,
                      input logic [15:0] exp);
      sb_item_t it;
      mem_ready = rdy;
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_dec(input string tag, input logic [5:0] op);
      instruction = op;
      cyc({tag, "_f"}, 1'b1, e_fa);
      cyc({tag, "_d"}, 1'b1, e_z);
   endtask

   initial begin
      e_z   = '0;
      e_fw  = mk(1,0,0,0,0,0,0,0,3'd0,0,0,0,0,0);
      e_fa  = mk(1,0,0,1,1,0,0,0,3'd0,0,0,0,0,0);
      e_ill = mk(0,0,0,0,0,0,0,0,3'd0,0,0,0,1,0);
      e_ma  = mk(0,0,0,0,0,0,0,0,3'd0,0,1,0,0,0);
      e_mr  = mk(1,0,1,0,0,0,0,0,3'd0,0,0,0,0,0);
      e_mwb = mk(0,0,0,0,0,0,1,1,3'd0,0,0,0,0,0);
      e_mw  = mk(0,1,1,0,0,0,0,0,3'd0,0,0,0,0,0);
      e_br  = mk(0,0,0,0,0,1,0,0,3'd0,0,0,0,0,0);
      e_hlt = mk(0,0,0,0,0,0,0,0,3'd0,0,0,1,0,0);
      e_hlf = mk(0,0,0,0,0,0,0,0,3'd0,0,0,1,0,1);

      rst = 1'b1;
      instruction = 6'd0;
      zero = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("idle", 1'b1, e_z);

      fetch_dec("reg", 6'b00_0010);
      cyc("reg_x", 1'b1, mk(0,0,0,0,0,0,1,0,3'b010,1,0,0,0,0));

      fetch_dec("imm", 6'b01_0101);
      cyc("imm_x", 1'b0, mk(0,0,0,0,0,0,1,0,3'b101,0,1,0,0,0));

      fetch_dec("ld", 6'b10_0000);
      cyc("ld_a", 1'b0, e_ma);
      repeat (3) cyc("ld_rd_wait", 1'b0, e_mr);
      cyc("ld_rd_ack", 1'b1, e_mr);
      cyc("ld_wb", 1'b0, e_mwb);

      instruction = 6'b11_0001;
      zero = 1'b1;
      repeat (2) cyc("f_wait", 1'b0, e_fw);
      cyc("bz1_f", 1'b1, e_fa);
      cyc("bz1_d", 1'b1, e_z);
      cyc("bz1_br", 1'b0, e_br);
      zero = 1'b0;
      fetch_dec("bz0", 6'b11_0001);
      cyc("bz0_br", 1'b0, e_z);
      zero = 1'b1;
      fetch_dec("bnz1", 6'b11_0010);
      cyc("bnz1_br", 1'b0, e_z);
      zero = 1'b0;
      fetch_dec("bnz0", 6'b11_0010);
      cyc("bnz0_br", 1'b0, e_br);
      zero = 1'b1;
      fetch_dec("jmp", 6'b11_0000);
      cyc("jmp_br", 1'b0, e_br);

      instruction = 6'b10_0101;
      cyc("ill_m_f", 1'b1, e_fa);
      cyc("ill_m_d", 1'b1, e_ill);
      instruction = 6'b00_1000;
      cyc("ill_r_f", 1'b1, e_fa);
      cyc("ill_r_d", 1'b1, e_ill);
      instruction = 6'b11_0011;
      cyc("ill_b_f", 1'b1, e_fa);
      cyc("ill_b_d", 1'b1, e_ill);

      fetch_dec("st", 6'b10_0001);
      cyc("st_a", 1'b1, e_ma);
      cyc("st_wr", 1'b1, e_mw);

      fetch_dec("st15", 6'b10_0001);
      cyc("st15_a", 1'b0, e_ma);
      repeat (14) cyc("st15_wait", 1'b0, e_mw);
      cyc("st15_ack", 1'b1, e_mw);

      fetch_dec("sto", 6'b10_0001);
      cyc("sto_a", 1'b0, e_ma);
      repeat (15) cyc("sto_wait", 1'b0, e_mw);
      repeat (3) cyc("sto_fault", 1'b1, e_hlf);
      rst = 1'b1;
      cyc("sto_rst", 1'b0, e_hlf);
      rst = 1'b0;
      cyc("sto_idle", 1'b1, e_z);

      fetch_dec("hlt", 6'b11_1111);
      repeat (4) cyc("hlt_hold", 1'b1, e_hlt);
      rst = 1'b1;
      cyc("hlt_rst", 1'b1, e_hlt);
      rst = 1'b0;
      cyc("hlt_idle", 1'b1, e_z);

      fetch_dec("ldr", 6'b10_0000);
      cyc("ldr_a", 1'b0, e_ma);
      cyc("ldr_rd", 1'b0, e_mr);
      rst = 1'b1;
      cyc("ldr_rd_rst", 1'b0, e_mr);
      rst = 1'b0;
      cyc("ldr_idle", 1'b1, e_z);
      cyc("ldr_f", 1'b1, e_fa);
      cyc("ldr_d", 1'b0, e_z);

      @(negedge clk);
      #1;
      check("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
